// File: rtl/tdm_demux_1to8_if.sv
// tdm_demux_1to8_if: serial slot input and parallel frame output of the TDM receiver
interface tdm_demux_1to8_if;
    logic       din;
    logic       din_valid;
    logic       frame_sync;
    logic       mode;
    logic [2:0] sel;
    logic [7:0] dout;
    logic       frame_valid;
    logic       frame_err;
    logic [2:0] slot_idx;
    modport master (
        output din, din_valid, frame_sync, mode, sel,
        input  dout, frame_valid, frame_err, slot_idx
    );
    modport slave (
        input  din, din_valid, frame_sync, mode, sel,
        output dout, frame_valid, frame_err, slot_idx
    );
endinterface

// File: rtl/tdm_demux_1to8.sv
// tdm_demux_1to8: receive end of an 8-slot TDM link, with a direct-select 1-to-8 demux mode
module tdm_demux_1to8 #(
    parameter int GAP_MAX = 15
) (
    input logic             clk,
    input logic             rst,
    tdm_demux_1to8_if.slave bus
);
    typedef enum logic {IDLE, COLLECT} state_t;
    localparam logic [7:0] GAP_LAST = 8'(GAP_MAX - 1);
    state_t     state, state_n;
    logic [2:0] slot_idx, slot_n;
    logic [7:0] gap, gap_n;
    logic [6:0] shadow, shadow_n;
    logic [7:0] dout, dout_n;
    logic       frame_valid, frame_err, fv_n, fe_n;
    always_comb begin
        state_n  = state;
        slot_n   = slot_idx;
        gap_n    = gap;
        shadow_n = shadow;
        dout_n   = dout;
        fv_n     = 1'b0;
        fe_n     = 1'b0;
        if (bus.mode) begin
            state_n = IDLE;
            slot_n  = 3'd0;
            gap_n   = 8'd0;
            if (bus.din_valid) dout_n[bus.sel] = bus.din;
        end else if (state == IDLE) begin
            if (bus.din_valid && bus.frame_sync) begin
                shadow_n[0] = bus.din;
                slot_n      = 3'd1;
                gap_n       = 8'd0;
                state_n     = COLLECT;
            end
        end else if (bus.din_valid && bus.frame_sync) begin
            // early sync restarts the frame on this slot
            fe_n        = 1'b1;
            shadow_n[0] = bus.din;
            slot_n      = 3'd1;
            gap_n       = 8'd0;
        end else if (bus.din_valid && slot_idx == 3'd7) begin
            dout_n  = {bus.din, shadow};
            fv_n    = 1'b1;
            slot_n  = 3'd0;
            state_n = IDLE;
        end else if (bus.din_valid) begin
            shadow_n[slot_idx] = bus.din;
            slot_n             = slot_idx + 3'd1;
            gap_n              = 8'd0;
        end else if (gap == GAP_LAST) begin
            fe_n    = 1'b1;
            slot_n  = 3'd0;
            gap_n   = 8'd0;
            state_n = IDLE;
        end else begin
            gap_n = gap + 8'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            slot_idx    <= 3'd0;
            gap         <= 8'd0;
            shadow      <= 7'd0;
            dout        <= 8'd0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_n;
            slot_idx    <= slot_n;
            gap         <= gap_n;
            shadow      <= shadow_n;
            dout        <= dout_n;
            frame_valid <= fv_n;
            frame_err   <= fe_n;
        end
    end
    assign bus.dout        = dout;
    assign bus.frame_valid = frame_valid;
    assign bus.frame_err   = frame_err;
    assign bus.slot_idx    = slot_idx;
endmodule
